// File: rtl/e1_chfifo_ctl.sv
// e1_chfifo_ctl: per-channel circular FIFOs for 21 E1 tributaries
// carved out of one shared dual-port RAM (port A write, port B read).
module e1_chfifo_ctl #(
    parameter int NCH      = 21,
    parameter int CHBIT    = 5,
    parameter int DEPTHBIT = 6,
    parameter int WIDTH    = 8,
    parameter int ADDRBIT  = CHBIT + DEPTHBIT
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               wr_vld,
    input  logic [CHBIT-1:0]   wr_ch,
    input  logic [WIDTH-1:0]   wr_dat,
    input  logic               rd_req,
    input  logic [CHBIT-1:0]   rd_ch,
    output logic               rd_vld,
    output logic [WIDTH-1:0]   rd_dat,
    input  logic               flush_vld,
    input  logic [CHBIT-1:0]   flush_ch,
    input  logic               sts_clr,
    output logic [NCH-1:0]     ovf,
    output logic [NCH-1:0]     udf,
    output logic               ch_err,
    output logic [ADDRBIT-1:0] ram_a0,
    output logic               ram_we0,
    output logic [WIDTH-1:0]   ram_di0,
    output logic [ADDRBIT-1:0] ram_a1,
    output logic               ram_we1,
    input  logic [WIDTH-1:0]   ram_do1
);

    localparam logic [CHBIT:0]    NCHV = (CHBIT+1)'(NCH);
    localparam logic [DEPTHBIT:0] FULL = {1'b1, {DEPTHBIT{1'b0}}};
    localparam logic [DEPTHBIT:0] EMPTY = '0;

    logic [DEPTHBIT-1:0] wptr [NCH];
    logic [DEPTHBIT-1:0] rptr [NCH];
    logic [DEPTHBIT:0]   cnt  [NCH];

    logic               wr_ok, rd_ok, fl_ok;
    logic [CHBIT-1:0]   wr_ix, rd_ix;
    logic [DEPTHBIT:0]  wr_cnt, rd_cnt;
    logic               wr_fl, rd_fl;
    logic               wr_act, rd_act;
    logic               wr_acc, rd_acc;
    logic               wr_drop, rd_drop;
    logic               err_set;
    logic [NCH-1:0]     wr_hit, rd_hit, fl_hit;
    logic [NCH-1:0]     ovf_set, udf_set;
    logic               rd_p1;

    assign wr_ok = {1'b0, wr_ch} < NCHV;
    assign rd_ok = {1'b0, rd_ch} < NCHV;
    assign fl_ok = {1'b0, flush_ch} < NCHV;

    // Keep array indices in range even when the id is illegal.
    assign wr_ix = wr_ok ? wr_ch : '0;
    assign rd_ix = rd_ok ? rd_ch : '0;

    assign wr_cnt = cnt[wr_ix];
    assign rd_cnt = cnt[rd_ix];

    assign wr_fl = flush_vld && fl_ok && (flush_ch == wr_ch);
    assign rd_fl = flush_vld && fl_ok && (flush_ch == rd_ch);

    assign wr_act  = wr_vld && wr_ok && !wr_fl;
    assign rd_act  = rd_req && rd_ok && !rd_fl;
    assign wr_acc  = wr_act && (wr_cnt != FULL);
    assign wr_drop = wr_act && (wr_cnt == FULL);
    assign rd_acc  = rd_act && (rd_cnt != EMPTY);
    assign rd_drop = rd_act && (rd_cnt == EMPTY);

    assign err_set = (wr_vld && !wr_ok)
                   || (rd_req && !rd_ok)
                   || (flush_vld && !fl_ok);

    always_comb begin
        wr_hit  = '0;
        rd_hit  = '0;
        fl_hit  = '0;
        ovf_set = '0;
        udf_set = '0;
        for (int i = 0; i < NCH; i++) begin
            wr_hit[i]  = wr_acc && (wr_ix == CHBIT'(i));
            rd_hit[i]  = rd_acc && (rd_ix == CHBIT'(i));
            fl_hit[i]  = flush_vld && fl_ok
                       && (flush_ch == CHBIT'(i));
            ovf_set[i] = wr_drop && (wr_ix == CHBIT'(i));
            udf_set[i] = rd_drop && (rd_ix == CHBIT'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            for (int i = 0; i < NCH; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
                cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (fl_hit[i]) begin
                    wptr[i] <= '0;
                    rptr[i] <= '0;
                    cnt[i]  <= '0;
                end else begin
                    if (wr_hit[i])
                        wptr[i] <= wptr[i] + 1'b1;
                    if (rd_hit[i])
                        rptr[i] <= rptr[i] + 1'b1;
                    if (wr_hit[i] && !rd_hit[i])
                        cnt[i] <= cnt[i] + 1'b1;
                    else if (rd_hit[i] && !wr_hit[i])
                        cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    // Sticky flags: a new event in the clear cycle survives.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            ovf    <= '0;
            udf    <= '0;
            ch_err <= 1'b0;
        end else begin
            ovf    <= (sts_clr ? '0 : ovf) | ovf_set;
            udf    <= (sts_clr ? '0 : udf) | udf_set;
            ch_err <= (sts_clr ? 1'b0 : ch_err) | err_set;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            ram_we0 <= 1'b0;
            ram_a0  <= '0;
            ram_di0 <= '0;
        end else begin
            ram_we0 <= wr_acc;
            if (wr_acc) begin
                ram_a0  <= {wr_ix, wptr[wr_ix]};
                ram_di0 <= wr_dat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            ram_a1 <= '0;
            rd_p1  <= 1'b0;
            rd_vld <= 1'b0;
        end else begin
            rd_p1  <= rd_acc;
            rd_vld <= rd_p1;
            if (rd_acc)
                ram_a1 <= {rd_ix, rptr[rd_ix]};
        end
    end

    assign rd_dat  = ram_do1;
    assign ram_we1 = 1'b0;

endmodule

// File: tb/tb_e1_chfifo_ctl.sv
// Directed bench for e1_chfifo_ctl with a behavioural dual-port RAM.
module tb_e1_chfifo_ctl;

    logic        clk = 1'b0;
    logic        rst_;
    logic        wr_vld;
    logic [4:0]  wr_ch;
    logic [7:0]  wr_dat;
    logic        rd_req;
    logic [4:0]  rd_ch;
    logic        rd_vld;
    logic [7:0]  rd_dat;
    logic        flush_vld;
    logic [4:0]  flush_ch;
    logic        sts_clr;
    logic [20:0] ovf;
    logic [20:0] udf;
    logic        ch_err;
    logic [10:0] ram_a0;
    logic        ram_we0;
    logic [7:0]  ram_di0;
    logic [10:0] ram_a1;
    logic        ram_we1;
    logic [7:0]  ram_do1;

    logic [7:0]  mem [2048];
    logic [7:0]  expq [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we0)
            mem[ram_a0] <= ram_di0;
        ram_do1 <= mem[ram_a1];
    end

    e1_chfifo_ctl dut (
        .clk(clk), .rst_(rst_),
        .wr_vld(wr_vld), .wr_ch(wr_ch), .wr_dat(wr_dat),
        .rd_req(rd_req), .rd_ch(rd_ch),
        .rd_vld(rd_vld), .rd_dat(rd_dat),
        .flush_vld(flush_vld), .flush_ch(flush_ch),
        .sts_clr(sts_clr),
        .ovf(ovf), .udf(udf), .ch_err(ch_err),
        .ram_a0(ram_a0), .ram_we0(ram_we0), .ram_di0(ram_di0),
        .ram_a1(ram_a1), .ram_we1(ram_we1), .ram_do1(ram_do1)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled at negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (rd_vld) begin
            if (expq.size() == 0)
                chk("rd_vld_unexpected", rd_vld, 0);
            else
                chk("rd_dat", rd_dat, expq.pop_front());
        end
    endtask

    task automatic idle();
        wr_vld = 0; rd_req = 0; flush_vld = 0; sts_clr = 0;
    endtask

    task automatic wr(input int ch, input int d);
        wr_vld = 1; wr_ch = 5'(ch); wr_dat = 8'(d);
    endtask

    task automatic rd(input int ch);
        rd_req = 1; rd_ch = 5'(ch);
    endtask

    initial begin
        rst_ = 0; wr_ch = 0; wr_dat = 0; rd_ch = 0; flush_ch = 0;
        ram_do1 = 0;
        idle();
        @(negedge clk);
        tick(); tick();
        chk("rst_we0", ram_we0, 0);
        chk("rst_a0", ram_a0, 0);
        chk("rst_a1", ram_a1, 0);
        chk("rst_rdvld", rd_vld, 0);
        chk("rst_flags", {ovf, udf, ch_err}, 0);
        chk("we1", ram_we1, 0);
        rst_ = 1;
        tick();

        // Three writes then three reads on ch 4
        wr(4, 8'h11); tick();
        chk("t1_we0", ram_we0, 1);
        chk("t1_a0_0", ram_a0, 11'h100);
        chk("t1_di0_0", ram_di0, 8'h11);
        wr(4, 8'h22); tick();
        chk("t1_a0_1", ram_a0, 11'h101);
        wr(4, 8'h33); tick();
        chk("t1_a0_2", ram_a0, 11'h102);
        chk("t1_di0_2", ram_di0, 8'h33);
        idle(); rd(4); expq.push_back(8'h11); tick();
        chk("t1_we0_off", ram_we0, 0);
        chk("t1_a1_0", ram_a1, 11'h100);
        chk("t1_rdvld_c4", rd_vld, 0);
        expq.push_back(8'h22); tick();
        chk("t1_rdvld_c5", rd_vld, 1);
        chk("t1_a1_1", ram_a1, 11'h101);
        expq.push_back(8'h33); tick();
        chk("t1_rdvld_c6", rd_vld, 1);
        idle(); tick();
        chk("t1_rdvld_c7", rd_vld, 1);
        tick();
        chk("t1_rdvld_c8", rd_vld, 0);

        // Fill ch 20, overflow, read back, wrap
        for (int i = 0; i < 64; i++) begin
            wr(20, i * 3 + 1); tick();
            chk("t2_we0", ram_we0, 1);
            chk("t2_a0", ram_a0, 11'h500 + 11'(i));
        end
        wr(20, 8'hAA); tick();
        chk("t2_drop_we0", ram_we0, 0);
        chk("t2_ovf20", ovf[20], 1);
        idle();
        for (int i = 0; i < 64; i++) begin
            rd(20); expq.push_back(8'(i * 3 + 1)); tick();
        end
        idle(); tick(); tick();
        chk("t2_drain", expq.size(), 0);
        chk("t2_a1_last", ram_a1, 11'h53F);
        wr(20, 8'h5C); tick();
        chk("t2_wrap_a0", ram_a0, 11'h500);
        idle(); rd(20); expq.push_back(8'h5C); tick();
        chk("t2_wrap_a1", ram_a1, 11'h500);
        idle(); tick(); tick();
        chk("t2_wrap_drain", expq.size(), 0);

        // Underflow and sticky clear
        rd(0); tick();
        chk("t3_udf0", udf[0], 1);
        chk("t3_a1_hold", ram_a1, 11'h500);
        idle(); tick();
        chk("t3_no_rdvld", rd_vld, 0);
        sts_clr = 1; tick();
        chk("t3_clr_udf", udf, 0);
        chk("t3_clr_ovf", ovf, 0);
        rd(0); tick();
        chk("t3_set_wins", udf[0], 1);
        idle(); tick();

        // Streaming on ch 7 with 10 entries held
        sts_clr = 1; tick(); idle();
        for (int k = 0; k < 10; k++) begin
            wr(7, k); tick();
        end
        for (int k = 0; k < 100; k++) begin
            wr(7, k + 10); rd(7); expq.push_back(8'(k));
            tick();
            chk("t4_we0", ram_we0, 1);
        end
        idle(); tick(); tick();
        chk("t4_drain", expq.size(), 0);
        chk("t4_udf7_none", udf[7], 0);
        for (int k = 0; k < 10; k++) begin
            rd(7); expq.push_back(8'(100 + k)); tick();
        end
        rd(7); tick();
        chk("t4_cnt10_udf7", udf[7], 1);
        idle(); tick(); tick();
        chk("t4_drain2", expq.size(), 0);

        // Full ch 7: write dropped, read accepted in the same cycle
        sts_clr = 1; tick(); idle();
        for (int k = 0; k < 64; k++) begin
            wr(7, 200 + k); tick();
        end
        chk("t4_full_noovf", ovf[7], 0);
        wr(7, 8'hEE); rd(7); expq.push_back(8'(200)); tick();
        chk("t4_full_drop", ram_we0, 0);
        chk("t4_full_ovf7", ovf[7], 1);
        chk("t4_full_a1", ram_a1, 11'h1EE);
        idle(); tick(); tick();
        chk("t4_full_drain", expq.size(), 0);
        flush_vld = 1; flush_ch = 7; tick(); idle();
        rd(7); tick();
        chk("t4_flush_udf7", udf[7], 1);
        idle(); tick(); tick();

        // Flush beats same-cycle write and read
        sts_clr = 1; tick(); idle();
        for (int k = 0; k < 5; k++) begin
            wr(3, 8'h30 + k); tick();
        end
        idle(); tick();
        flush_vld = 1; flush_ch = 3; wr(3, 8'h99); rd(3); tick();
        chk("t5_no_we0", ram_we0, 0);
        chk("t5_a1_hold", ram_a1, 11'h1EE);
        chk("t5_flags", {ovf, udf, ch_err}, 0);
        idle(); tick();
        chk("t5_no_rdvld", rd_vld, 0);
        rd(3); tick();
        chk("t5_udf3", udf[3], 1);
        idle(); wr(3, 8'h42); tick();
        chk("t5_wptr0_we0", ram_we0, 1);
        chk("t5_wptr0_a0", ram_a0, 11'h0C0);
        idle(); tick();

        // Illegal channel ids
        wr(21, 8'h77); rd(31); tick();
        chk("t6_no_we0", ram_we0, 0);
        chk("t6_ch_err", ch_err, 1);
        chk("t6_a1_hold", ram_a1, 11'h1EE);
        idle(); tick();
        chk("t6_no_rdvld", rd_vld, 0);
        sts_clr = 1; tick();
        chk("t6_clr_cherr", ch_err, 0);
        idle();

        // Reset with a read and write in flight
        rd(3); wr(5, 8'h55); flush_vld = 1; flush_ch = 30; tick();
        chk("t7_we0", ram_we0, 1);
        chk("t7_a1", ram_a1, 11'h0C0);
        chk("t7_cherr", ch_err, 1);
        idle(); rst_ = 0; tick();
        chk("t7_rdvld", rd_vld, 0);
        chk("t7_we0_rst", ram_we0, 0);
        chk("t7_a0_rst", ram_a0, 0);
        chk("t7_di0_rst", ram_di0, 0);
        chk("t7_a1_rst", ram_a1, 0);
        chk("t7_flags_rst", {ovf, udf, ch_err}, 0);
        rst_ = 1; tick();
        chk("t7_rdvld_after", rd_vld, 0);
        rd(5); tick();
        chk("t7_ch5_empty", udf[5], 1);
        idle(); tick(); tick();
        chk("t7_rdvld_end", rd_vld, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
